// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, S-box, Rcon and key-schedule state encoding
package aes_pkg;

  localparam int AES_KEY_WIDTH  = 128;
  localparam int AES_NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } aes_ks_state_e;

  // Row-major S-box: entry 0 occupies the most significant byte.
  localparam logic [2047:0] AES_SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    return AES_SBOX_TBL[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] aes_rcon(input logic [3:0] k);
    logic [7:0] r;
    case (k)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// rtl/aes_key_round.sv - one combinational AES-128 key expansion step
module aes_key_round
  import aes_pkg::*;
(
  input  logic [AES_KEY_WIDTH-1:0] key_i,
  input  logic [7:0]               rcon_i,
  output logic [AES_KEY_WIDTH-1:0] next_key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, t;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_i;
  assign rot = {w3[23:0], w3[31:24]};
  assign t   = {aes_sbox(rot[31:24]) ^ rcon_i,
                aes_sbox(rot[23:16]),
                aes_sbox(rot[15:8]),
                aes_sbox(rot[7:0])};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// rtl/aes_key_schedule_ctrl.sv - iterative AES-128 key schedule, one round key per clock,
// with an 11-entry round-key file and registered read port
module aes_key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int KEY_WIDTH  = AES_KEY_WIDTH,
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_aes_key_schedule_ctrl_clk,
  input  logic                  i_aes_key_schedule_ctrl_rst_n,
  input  logic                  i_aes_key_schedule_ctrl_start,
  input  logic [KEY_WIDTH-1:0]  i_aes_key_schedule_ctrl_key,
  input  logic [ADDR_WIDTH-1:0] i_aes_key_schedule_ctrl_rd_addr,
  output logic [KEY_WIDTH-1:0]  o_aes_key_schedule_ctrl_rd_key,
  output logic                  o_aes_key_schedule_ctrl_busy,
  output logic                  o_aes_key_schedule_ctrl_done,
  output logic                  o_aes_key_schedule_ctrl_keys_valid
);

  aes_ks_state_e         state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [KEY_WIDTH-1:0]  work_q, work_d;
  logic                  done_q, done_d;
  logic [KEY_WIDTH-1:0]  rd_key_q, rd_key_d;
  logic [KEY_WIDTH-1:0]  keys_q [0:NUM_ROUNDS];

  logic                  wr_en;
  logic [3:0]            wr_idx;
  logic [KEY_WIDTH-1:0]  wr_data;
  logic [KEY_WIDTH-1:0]  next_key;

  aes_key_round u_round (
    .key_i      (work_q),
    .rcon_i     (aes_rcon(cnt_q)),
    .next_key_o (next_key)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = 4'd0;
    wr_data = next_key;
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (i_aes_key_schedule_ctrl_start) begin
          wr_en   = 1'b1;
          wr_data = i_aes_key_schedule_ctrl_key;
          work_d  = i_aes_key_schedule_ctrl_key;
          cnt_d   = 4'd1;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        // start is deliberately not looked at here: an in-flight expansion is never restarted.
        wr_en  = 1'b1;
        wr_idx = cnt_q;
        work_d = next_key;
        if (cnt_q == 4'(NUM_ROUNDS)) begin
          state_d = ST_READY;
          done_d  = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    rd_key_d = '0;
    if (i_aes_key_schedule_ctrl_rd_addr <= ADDR_WIDTH'(NUM_ROUNDS)) begin
      rd_key_d = keys_q[i_aes_key_schedule_ctrl_rd_addr];
    end
  end

  always_ff @(posedge i_aes_key_schedule_ctrl_clk or negedge i_aes_key_schedule_ctrl_rst_n) begin
    if (!i_aes_key_schedule_ctrl_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      work_q   <= '0;
      done_q   <= 1'b0;
      rd_key_q <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        keys_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      done_q   <= done_d;
      rd_key_q <= rd_key_d;
      if (wr_en) begin
        keys_q[wr_idx] <= wr_data;
      end
    end
  end

  assign o_aes_key_schedule_ctrl_rd_key     = rd_key_q;
  assign o_aes_key_schedule_ctrl_busy       = (state_q == ST_EXPAND);
  assign o_aes_key_schedule_ctrl_done       = done_q;
  assign o_aes_key_schedule_ctrl_keys_valid = (state_q == ST_READY);

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// tb/tb_aes_key_schedule_ctrl.sv - directed, table-driven bench for aes_key_schedule_ctrl
module tb_aes_key_schedule_ctrl;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] exp;
  } rd_vec_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;
  logic         busy;
  logic         done;
  logic         keys_valid;

  int total = 0;
  int bad   = 0;

  aes_key_schedule_ctrl dut (
    .i_aes_key_schedule_ctrl_clk        (clk),
    .i_aes_key_schedule_ctrl_rst_n      (rst_n),
    .i_aes_key_schedule_ctrl_start      (start),
    .i_aes_key_schedule_ctrl_key        (key),
    .i_aes_key_schedule_ctrl_rd_addr    (rd_addr),
    .o_aes_key_schedule_ctrl_rd_key     (rd_key),
    .o_aes_key_schedule_ctrl_busy       (busy),
    .o_aes_key_schedule_ctrl_done       (done),
    .o_aes_key_schedule_ctrl_keys_valid (keys_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k);
    start = 1'b1;
    key   = k;
    tick();
    start = 1'b0;
  endtask

  // Counts edges from the accepted start to the done pulse; busy must hold until then.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 40) begin
      chk({name, "_busy"}, {127'd0, busy}, 128'd1);
      tick();
      n++;
    end
    chk({name, "_latency"}, 128'(n), 128'd10);
    chk({name, "_kv_at_done"}, {127'd0, keys_valid}, 128'd1);
    chk({name, "_busy_at_done"}, {127'd0, busy}, 128'd0);
  endtask

  task automatic run_reads(input string name, input rd_vec_t v[$]);
    for (int i = 0; i < v.size(); i++) begin
      rd_addr = v[i].addr;
      tick();
      chk($sformatf("%s_rd%0d", name, v[i].addr), rd_key, v[i].exp);
    end
  endtask

  initial begin
    rd_vec_t k1_tbl[$];
    rd_vec_t k2_tbl[$];
    rd_vec_t hi_tbl[$];
    int      dones;

    k1_tbl = '{'{4'd0, K1}, '{4'd1, K1_R1}, '{4'd2, K1_R2}, '{4'd10, K1_R10}};
    k2_tbl = '{'{4'd0, K2}, '{4'd10, K2_R10}};
    hi_tbl = '{'{4'd11, 128'd0}, '{4'd15, 128'd0}};

    rst_n = 1'b0; start = 1'b0; key = '0; rd_addr = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // 1: reset state
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd0);
    chk("rst_kv", {127'd0, keys_valid}, 128'd0);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      tick();
      chk($sformatf("rst_rd%0d", a), rd_key, 128'd0);
    end

    // 2: FIPS-197 key
    do_start(K1);
    chk("t2_kv_low", {127'd0, keys_valid}, 128'd0);
    wait_done("t2");
    tick();
    chk("t2_done_one", {127'd0, done}, 128'd0);
    run_reads("t2", k1_tbl);
    rd_addr = 4'd0;
    tick();
    rd_addr = 4'd1;
    #1;
    chk("t2_rd_latency_hold", rd_key, K1);
    tick();
    chk("t2_rd_latency_new", rd_key, K1_R1);

    // 3: start during EXPAND is ignored
    do_start(K1);
    repeat (3) tick();
    do_start(K2);
    begin
      int n;
      n = 4;
      while (!done && n < 40) begin
        tick();
        n++;
      end
      chk("t3_latency", 128'(n), 128'd10);
    end
    run_reads("t3", '{'{4'd0, K1}, '{4'd10, K1_R10}});

    // 4: restart from READY
    chk("t4_kv_before", {127'd0, keys_valid}, 128'd1);
    do_start(K2);
    chk("t4_kv_drop", {127'd0, keys_valid}, 128'd0);
    wait_done("t4");
    run_reads("t4", k2_tbl);

    // 5: async reset mid-EXPAND
    do_start(K1);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", {127'd0, busy}, 128'd0);
    chk("t5_done", {127'd0, done}, 128'd0);
    chk("t5_kv", {127'd0, keys_valid}, 128'd0);
    chk("t5_rdkey", rd_key, 128'd0);
    dones = 0;
    repeat (8) begin
      tick();
      if (done) dones++;
    end
    rst_n = 1'b1;
    run_reads("t5_cleared", '{'{4'd0, 128'd0}, '{4'd10, 128'd0}});
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dones++;
    end
    chk("t5_no_done", 128'(dones), 128'd0);
    do_start(K2);
    wait_done("t5");
    run_reads("t5", k2_tbl);

    // 6: out-of-range reads and three back-to-back expansions
    run_reads("t6", hi_tbl);
    start = 1'b1;
    key   = K1;
    for (int e = 0; e < 3; e++) begin
      key = (e == 1) ? K2 : K1;
      tick();
      start = 1'b0;
      if (e > 0) chk($sformatf("t6_done_fall%0d", e), {127'd0, done}, 128'd0);
      chk($sformatf("t6_busy%0d", e), {127'd0, busy}, 128'd1);
      wait_done($sformatf("t6_e%0d", e));
      start = (e < 2);
    end
    tick();
    chk("t6_done_last", {127'd0, done}, 128'd0);
    chk("t6_kv_last", {127'd0, keys_valid}, 128'd1);
    run_reads("t6_final", '{'{4'd10, K1_R10}, '{4'd11, 128'd0}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule_ctrl.md
Name: aes_key_schedule_ctrl

Overview:
Iterative AES-128 key-schedule controller. It replaces the fully unrolled combinational expansion with a sequenced datapath that computes one round key per clock. Each result is stored in an 11-entry round-key register file, which the cipher round sequencer reads through a registered read port. A start/busy/done handshake frames each expansion.

Parameters:
- KEY_WIDTH, 128, cipher key and round-key width; only 128 is supported.
- NUM_ROUNDS, 10, number of expansion rounds; round keys are indexed 0..NUM_ROUNDS.
- ADDR_WIDTH, 4, width of the round-key read address.

Ports:
- i_aes_key_schedule_ctrl_clk  in  1  clock; all flops are rising-edge.
- i_aes_key_schedule_ctrl_rst_n  in  1  asynchronous active-low reset.
- i_aes_key_schedule_ctrl_start  in  1  single-cycle request to expand the key.
- i_aes_key_schedule_ctrl_key  in  KEY_WIDTH  cipher key, sampled only on an accepted start.
- i_aes_key_schedule_ctrl_rd_addr  in  ADDR_WIDTH  round-key index to read.
- o_aes_key_schedule_ctrl_rd_key  out  KEY_WIDTH  registered read data.
- o_aes_key_schedule_ctrl_busy  out  1  expansion in progress.
- o_aes_key_schedule_ctrl_done  out  1  one-cycle pulse when round key 10 is stored.
- o_aes_key_schedule_ctrl_keys_valid  out  1  all 11 round keys are stable and readable.

Behaviour:
- Reset (async assert, sync deassert by the system) clears:
  - state to IDLE and the round counter to 0;
  - busy, done, keys_valid and rd_key to 0;
  - all 11 key registers to 0.
- States:
  - IDLE: no keys yet.
  - EXPAND: rounds in flight.
  - READY: keys held.
- IDLE/READY, start=1 at edge E0:
  - key register 0 <= i_key; working key <= i_key; round counter <= 1.
  - State -> EXPAND; busy=1; keys_valid=0.
- EXPAND, at each edge Ek (k = 1..10):
  - Compute next = round_fn(working key, Rcon[k]).
  - Store it in key register k; working key <= next; counter <= k+1.
- At E10:
  - State -> READY; busy=0; done=1 for exactly one cycle (deasserted at E11); keys_valid=1.
- Latency: done is high in the cycle after E10, i.e. 10 cycles after start is sampled. Throughput is one expansion per 11 cycles when start is issued back-to-back from READY.
- start while in EXPAND is ignored: no restart, no key resample, no error flag.
- start in READY restarts expansion:
  - keys_valid falls at the same edge;
  - key registers 1..10 keep stale values until overwritten, but are not guaranteed valid until the next done.
- start at the edge where done is asserted is legal and is accepted as a READY start.
- Read port:
  - rd_key <= keyreg[rd_addr] at every edge, in any state (1-cycle latency).
  - rd_addr > 10 returns 0.
  - Reads during EXPAND return current register contents; the consumer must gate them with keys_valid.
- round_fn(w0,w1,w2,w3), with w0 the most significant word:
  - t = SubWord(RotWord(w3)) ^ {Rcon,24'h0}
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
  - Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- Async reset mid-EXPAND aborts immediately to IDLE with all outputs and registers at their reset values; no partial done is produced.
- The counter never exceeds 10: no wrap, and no illegal state is reachable. An undefined state encoding recovers to IDLE.

Decomposition:
- Shared package aes_pkg holds:
  - the 256-entry S-box constant function;
  - the Rcon table (indexed 1..10);
  - the state typedef/localparams (IDLE, EXPAND, READY);
  - the AES_NUM_ROUNDS and AES_KEY_WIDTH constants.
- One combinational sub-module, aes_key_round, implements round_fn: inputs are the 128-bit key and the 8-bit Rcon, output is the 128-bit next key. It uses four S-box lookups.
- The controller contains only the FSM, round counter, key register file and read port.

Test Plan:
1. Reset with all inputs idle -> busy=0, done=0, keys_valid=0, rd_key=0 for every rd_addr 0..15.
2. start with key 2b7e151628aed2a6abf7158809cf4f3c -> the following must hold:
   - busy for 10 cycles, then a done pulse with keys_valid=1;
   - addr 0 reads 2b7e151628aed2a6abf7158809cf4f3c;
   - addr 1 reads a0fafe1788542cb123a339392a6c7605;
   - addr 2 reads f2c295f27a96b9435935807a7359f67f;
   - addr 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6;
   - each read arrives one cycle after the address is applied.
3. Pulse start again at cycle 4 of EXPAND with key 000102030405060708090a0b0c0d0e0f -> ignored: done still arrives at the original time, and addr 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
4. From READY, start with key 000102030405060708090a0b0c0d0e0f -> keys_valid drops the same edge; after done, addr 10 = 13111d7fe3944a17f307a78b4d2b30c5.
5. Assert rst_n low asynchronously at cycle 6 of EXPAND -> all outputs 0 immediately, no done pulse, and a fresh start afterwards completes normally.
6. rd_addr = 11 and rd_addr = 15 while READY -> rd_key = 0; done is high for exactly one cycle per expansion across three back-to-back expansions.
